seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver_pkg.sv | 41 ++++
 rtl/bcd_to_7seg.sv | 13 +
 rtl/seg_display_driver.sv | 102 ++++++++++
 tb/tb_seg_display_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_driver_pkg.sv
// Shared display constants for the multiplexed 4-digit seven-segment driver.
// All patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_display_driver_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [3:0] AnOff    = 4'b1111;
    localparam scan_idx_t  DpIdx    = 2'd2;

    localparam logic [6:0] Seg0 = 7'b1000000;
    localparam logic [6:0] Seg1 = 7'b1111001;
    localparam logic [6:0] Seg2 = 7'b0100100;
    localparam logic [6:0] Seg3 = 7'b0110000;
    localparam logic [6:0] Seg4 = 7'b0011001;
    localparam logic [6:0] Seg5 = 7'b0010010;
    localparam logic [6:0] Seg6 = 7'b0000010;
    localparam logic [6:0] Seg7 = 7'b1111000;
    localparam logic [6:0] Seg8 = 7'b0000000;
    localparam logic [6:0] Seg9 = 7'b0010000;

    // Non-BCD codes 10-15 fall through to blank.
    function automatic logic [6:0] digit_pattern(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = Seg0;
            4'd1:    pat = Seg1;
            4'd2:    pat = Seg2;
            4'd3:    pat = Seg3;
            4'd4:    pat = Seg4;
            4'd5:    pat = Seg5;
            4'd6:    pat = Seg6;
            4'd7:    pat = Seg7;
            4'd8:    pat = Seg8;
            4'd9:    pat = Seg9;
            default: pat = SegBlank;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 are blank.
module bcd_to_7seg
    import seg_display_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = digit_pattern(bcd_i);
    end

endmodule

// File: rtl/seg_display_driver.sv
// Time-multiplexed 4-digit seven-segment driver with blinking adjust pair.
// Outputs are registered from the scan index in effect before each edge.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seconds_ones,
    input  logic [3:0] seconds_tens,
    input  logic [3:0] minutes_ones,
    input  logic [3:0] minutes_tens,
    input  logic       adjust,
    input  logic       select,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RefreshW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BlinkW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RefreshW-1:0] RefreshMax = RefreshW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0]   BlinkMax   = BlinkW'(BLINK_DIV - 1);

    logic [RefreshW-1:0] refresh_q, refresh_d;
    logic [BlinkW-1:0]   blink_q, blink_d;
    scan_idx_t           scan_q, scan_d;
    logic                blink_on_q, blink_on_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [3:0] cur_digit;
    logic [6:0] dec_seg;
    logic       blank;

    always_comb begin
        unique case (scan_q)
            2'd0:    cur_digit = seconds_ones;
            2'd1:    cur_digit = seconds_tens;
            2'd2:    cur_digit = minutes_ones;
            default: cur_digit = minutes_tens;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        refresh_d = refresh_q + RefreshW'(1);
        scan_d    = scan_q;
        if (refresh_q == RefreshMax) begin
            refresh_d = '0;
            scan_d    = scan_q + 2'd1;
        end

        blink_d    = blink_q + BlinkW'(1);
        blink_on_d = blink_on_q;
        if (blink_q == BlinkMax) begin
            blink_d    = '0;
            blink_on_d = ~blink_on_q;
        end
    end

    // scan_q[1] distinguishes the minutes pair (1) from the seconds pair (0).
    always_comb begin
        blank = adjust && !blink_on_q && (select == scan_q[1]);
        an_d  = ~(4'b0001 << scan_q);
        seg_d = blank ? SegBlank : dec_seg;
        dp_d  = !((scan_q == DpIdx) && !blank);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q  <= '0;
            blink_q    <= '0;
            scan_q     <= '0;
            blink_on_q <= 1'b1;
            an_q       <= AnOff;
            seg_q      <= SegBlank;
            dp_q       <= 1'b1;
        end else begin
            refresh_q  <= refresh_d;
            blink_q    <= blink_d;
            scan_q     <= scan_d;
            blink_on_q <= blink_on_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: an arithmetic reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_seg_display_driver;

    localparam int unsigned R = 4;
    localparam int unsigned B = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] seconds_ones, seconds_tens, minutes_ones, minutes_tens;
    logic       adjust, select;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    seg_display_driver #(
        .REFRESH_DIV (R),
        .BLINK_DIV   (B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seconds_ones (seconds_ones),
        .seconds_tens (seconds_tens),
        .minutes_ones (minutes_ones),
        .minutes_tens (minutes_tens),
        .adjust       (adjust),
        .select       (select),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: n counts non-reset edges since the last reset edge, so the
    // digit shown at edge n is (n/R)%4 and blink_on is on during even (n/B) periods.
    int         n = 0;
    bit         model_valid = 0;
    int         m_s;
    bit         m_bon, m_blank;
    logic [3:0] m_d, e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    always @(posedge clk) begin
        if (!rst) begin
            e_an        = 4'b1111;
            e_seg       = 7'b1111111;
            e_dp        = 1'b1;
            n           = 0;
            model_valid = 1;
        end else begin
            m_s   = (n / R) % 4;
            m_bon = ((n / B) % 2) == 0;
            case (m_s)
                0:       m_d = seconds_ones;
                1:       m_d = seconds_tens;
                2:       m_d = minutes_ones;
                default: m_d = minutes_tens;
            endcase
            m_blank = adjust && !m_bon && ((select && m_s >= 2) || (!select && m_s < 2));
            e_an       = 4'b1111;
            e_an[m_s]  = 1'b0;
            e_seg      = m_blank ? 7'b1111111 : ref_seg(m_d);
            e_dp       = !(m_s == 2 && !m_blank);
            n++;
        end
        #1;
        if (model_valid) begin
            check("model_an", {3'b0, an}, {3'b0, e_an});
            check("model_seg", seg, e_seg);
            check("model_dp", {6'b0, dp}, {6'b0, e_dp});
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Release reset, then stop just after post-reset edge number k.
    task automatic release_to(input int k);
        @(negedge clk);
        rst = 1'b1;
        repeat (k + 1) @(posedge clk);
        #2;
    endtask

    task automatic advance(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        rst          = 1'b0;
        seconds_ones = 4'd2;
        seconds_tens = 4'd3;
        minutes_ones = 4'd4;
        minutes_tens = 4'd5;
        adjust       = 1'b0;
        select       = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_an", {3'b0, an}, 7'b0001111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_dp", {6'b0, dp}, 7'b0000001);

        release_to(0);
        check("scan0_an", {3'b0, an}, 7'b0001110);
        check("scan0_seg", seg, 7'b0100100);
        check("scan0_dp", {6'b0, dp}, 7'b0000001);
        advance(4);
        check("scan1_an", {3'b0, an}, 7'b0001101);
        check("scan1_seg", seg, 7'b0110000);
        advance(4);
        check("scan2_an", {3'b0, an}, 7'b0001011);
        check("scan2_seg", seg, 7'b0011001);
        check("scan2_dp", {6'b0, dp}, 7'b0000000);
        advance(4);
        check("scan3_an", {3'b0, an}, 7'b0000111);
        check("scan3_seg", seg, 7'b0010010);

        // Reset for one clock while digit 3 is selected.
        @(negedge clk);
        rst = 1'b0;
        advance(1);
        check("midrst_an", {3'b0, an}, 7'b0001111);
        check("midrst_seg", seg, 7'b1111111);
        release_to(0);
        check("postrst_an", {3'b0, an}, 7'b0001110);
        advance(80);

        // Seconds pair blinking.
        reset_dut();
        adjust = 1'b1;
        select = 1'b0;
        release_to(16);
        check("blk_sec_an", {3'b0, an}, 7'b0001110);
        check("blk_sec_seg", seg, 7'b1111111);
        advance(8);
        check("blk_sec_min_seg", seg, 7'b0011001);
        check("blk_sec_min_dp", {6'b0, dp}, 7'b0000000);
        advance(60);

        // Dropping adjust during the off phase unblanks on the next update.
        reset_dut();
        release_to(16);
        check("adj_pre_seg", seg, 7'b1111111);
        @(negedge clk);
        adjust = 1'b0;
        advance(1);
        check("adj_post_seg", seg, 7'b0100100);
        adjust = 1'b1;

        // Minutes pair blinking.
        reset_dut();
        select = 1'b1;
        release_to(8);
        check("blk_min_on_seg", seg, 7'b0011001);
        check("blk_min_on_dp", {6'b0, dp}, 7'b0000000);
        advance(16);
        check("blk_min_off_an", {3'b0, an}, 7'b0001011);
        check("blk_min_off_seg", seg, 7'b1111111);
        check("blk_min_off_dp", {6'b0, dp}, 7'b0000001);
        advance(4);
        check("blk_min_off3_seg", seg, 7'b1111111);
        advance(64);

        // Non-BCD code on seconds ones.
        reset_dut();
        adjust       = 1'b0;
        seconds_ones = 4'hC;
        release_to(0);
        check("hexC_an", {3'b0, an}, 7'b0001110);
        check("hexC_seg", seg, 7'b1111111);
        advance(4);
        check("hexC_next_seg", seg, 7'b0110000);

        // Sweep all codes through every position; the model checks each cycle.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            seconds_ones = 4'(v);
            seconds_tens = 4'((v + 5) % 16);
            minutes_ones = 4'((v + 10) % 16);
            minutes_tens = 4'((v + 15) % 16);
            adjust       = v[2];
            select       = v[0];
            repeat (7) @(posedge clk);
        end
        advance(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
